// File: rtl/instr_queue_if.sv
// Shared entry type and handshake interface for the decode -> rename
// instruction queue.
//   instr_queue_pkg::instruction_info_reg_t : decoded instruction entry,
//     carried through the queue unmodified.
//   instr_queue_if : enq_valid/enq_ready/enq_data (producer side),
//     deq_valid/deq_ready/deq_data (consumer side), plus occupancy status
//     count/full/empty/almost_full.
//     master modport: decode/dispatch side (drives enq_*, deq_ready).
//     slave modport : the queue itself.

package instr_queue_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc_next;
        logic [31:0] instr;
        logic [4:0]  rd;
        logic        predict_branch;
        logic        valid;
    } instruction_info_reg_t;

endpackage

interface instr_queue_if #(
    parameter int unsigned DEPTH = 16
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic                                   enq_valid;
    logic                                   enq_ready;
    instr_queue_pkg::instruction_info_reg_t enq_data;
    logic                                   deq_valid;
    logic                                   deq_ready;
    instr_queue_pkg::instruction_info_reg_t deq_data;
    logic [CW-1:0]                          count;
    logic                                   full;
    logic                                   empty;
    logic                                   almost_full;

    modport master (
        output enq_valid, enq_data, deq_ready,
        input  enq_ready, deq_valid, deq_data, count, full, empty, almost_full
    );

    modport slave (
        input  enq_valid, enq_data, deq_ready,
        output enq_ready, deq_valid, deq_data, count, full, empty, almost_full
    );

endinterface

// File: rtl/instr_queue.sv
// instr_queue: circular FIFO between decode and rename/dispatch.
// Buffers decoded entries in program order and presents the oldest at the
// head. A flush empties the queue in one cycle.
// Ports:
//   clk    : clock, all state updates on the rising edge
//   rst_n  : asynchronous active-low reset
//   flush  : synchronous discard of all entries (highest priority)
//   q      : instr_queue_if.slave - enq/deq handshakes and occupancy status
// Parameters:
//   DEPTH     : number of entries, power of two, >= 4
//   AF_THRESH : almost_full when count >= AF_THRESH (1..DEPTH)

module instr_queue #(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned AF_THRESH = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    instr_queue_if.slave  q
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW-1:0] count;
    logic          full;
    logic          empty;
    logic          enq_fire;
    logic          deq_fire;

    instr_queue_pkg::instruction_info_reg_t mem [DEPTH];

    // Status comes from registered pointers only; enq_ready deliberately
    // ignores deq_ready so there is no combinational path between them.
    always_comb begin
        full     = (head[AW-1:0] == tail[AW-1:0]) && (head[AW] != tail[AW]);
        empty    = (head == tail);
        count    = tail - head;
        enq_fire = q.enq_valid && !full && !flush;
        deq_fire = q.deq_ready && !empty && !flush;
    end

    assign q.enq_ready   = !full && !flush;
    assign q.deq_valid   = !empty && !flush;
    assign q.deq_data    = mem[head[AW-1:0]];
    assign q.count       = count;
    assign q.full        = full;
    assign q.empty       = empty;
    assign q.almost_full = (count >= PW'(AF_THRESH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
        end else if (flush) begin
            head <= '0;
            tail <= '0;
        end else begin
            if (enq_fire) tail <= tail + 1'b1;
            if (deq_fire) head <= head + 1'b1;
        end
    end

    // Storage is not reset; contents are only observable while deq_valid=1.
    always_ff @(posedge clk) begin
        if (enq_fire) mem[tail[AW-1:0]] <= q.enq_data;
    end

endmodule
